// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and constants for the CORDIC back-end stages.
//   CORDIC_W        data width of CORDIC magnitude/angle words
//   K_COEF_DEFAULT  CORDIC gain reciprocal, Q1.15 (19899 ~ 0.60725 * 2^15)
//   ROUND_BIAS      half-LSB of the Q15 product, for round-half-up
//   gc_state_t      gain-compensation FSM states
//   result_t        one queued (magnitude, angle) result
package cordic_pkg;

    localparam int          CORDIC_W       = 16;
    localparam logic [15:0] K_COEF_DEFAULT = 16'h4DBB;
    localparam logic [31:0] ROUND_BIAS     = 32'h4000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        PUSH = 2'd2
    } gc_state_t;

    typedef struct packed {
        logic [CORDIC_W-1:0] mag;
        logic [CORDIC_W-1:0] ang;
    } result_t;

endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous show-ahead FIFO of result_t.
//   clk, rst_n   clock, asynchronous active-low reset (empties the queue)
//   push, wdata  write request and entry; accepted when not full, or when
//                a pop happens in the same cycle
//   pop          read request; ignored when empty
//   rdata        head entry; holds the last popped entry while empty
//   full, empty  occupancy flags
module result_fifo
    import cordic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  result_t wdata,
    input  logic    pop,
    output result_t rdata,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    result_t        mem_q [DEPTH];
    result_t        last_q;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = empty ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp: removes the CORDIC gain from the vector-mode magnitude.
// Captures (rootxy, atanba) on the done strobe, multiplies rootxy by K_COEF
// with a 16-cycle LSB-first shift-add, rounds half-up back to 16 bits and
// queues (magnitude, angle) in a show-ahead FIFO.
//   Clk, Reset          clock, asynchronous active-low reset
//   data_in_vec         one-cycle strobe: rootxy/atanba valid
//   rootxy, atanba      raw magnitude (unsigned), angle (passed through)
//   mag_out, ang_out    FIFO head
//   out_valid/out_ready output handshake, pop on both high
//   busy                a result is being computed or waiting for a slot
//   overrun             sticky: a strobe arrived while busy and was dropped
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] K_COEF     = K_COEF_DEFAULT
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                data_in_vec,
    input  logic [CORDIC_W-1:0] rootxy,
    input  logic [CORDIC_W-1:0] atanba,
    output logic [CORDIC_W-1:0] mag_out,
    output logic [CORDIC_W-1:0] ang_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                overrun
);

    gc_state_t           state_q, state_d;
    logic [3:0]          iter_q, iter_d;
    logic                overrun_q, overrun_d;
    logic [CORDIC_W-1:0] mcand_q, mcand_d;
    logic [CORDIC_W-1:0] ang_q, ang_d;
    logic [31:0]         acc_q, acc_d;

    logic    fifo_full, fifo_empty, fifo_push, fifo_pop;
    result_t fifo_wdata, fifo_rdata;

    // Q15 product back to an integer, rounding half up. K < 1 keeps the
    // result within 16 bits, so no saturation.
    function automatic logic [CORDIC_W-1:0] round_q15(input logic [31:0] a);
        logic [31:0] s;
        s = a + ROUND_BIAS;
        return CORDIC_W'(s >> 15);
    endfunction

    assign fifo_pop   = out_valid && out_ready;
    assign fifo_push  = (state_q == PUSH) && (!fifo_full || fifo_pop);
    assign fifo_wdata = '{mag: round_q15(acc_q), ang: ang_q};

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        mcand_d   = mcand_q;
        ang_d     = ang_q;
        acc_d     = acc_q;
        overrun_d = overrun_q | (data_in_vec && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (data_in_vec) begin
                    mcand_d = rootxy;
                    ang_d   = atanba;
                    acc_d   = '0;
                    iter_d  = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (K_COEF[iter_q])
                    acc_d = acc_q + (32'(mcand_q) << iter_q);
                iter_d = iter_q + 1'b1;
                if (iter_q == 4'd15) state_d = PUSH;
            end
            PUSH: begin
                // Stay here while the queue is full and nothing is popped.
                if (fifo_push) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            iter_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            overrun_q <= overrun_d;
        end
    end

    // Datapath registers: only meaningful after a capture in IDLE.
    always_ff @(posedge Clk) begin
        mcand_q <= mcand_d;
        ang_q   <= ang_d;
        acc_q   <= acc_d;
    end

    result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (Clk),
        .rst_n(Reset),
        .push (fifo_push),
        .wdata(fifo_wdata),
        .pop  (fifo_pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign mag_out   = fifo_rdata.mag;
    assign ang_out   = fifo_rdata.ang;
    assign out_valid = !fifo_empty;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cordic_gain_comp.sv
module tb_cordic_gain_comp;

    logic        Clk;
    logic        Reset;
    logic        data_in_vec;
    logic [15:0] rootxy;
    logic [15:0] atanba;
    logic [15:0] mag_out;
    logic [15:0] ang_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed: round((r * 19899) / 32768), half up.
    logic [15:0] vr [5] = '{16'h8000, 16'h0100, 16'd1000, 16'h0001, 16'h4000};
    logic [15:0] va [5] = '{16'h0001, 16'h8001, 16'h7FFF, 16'hFFFF, 16'h1234};
    logic [15:0] em [5] = '{16'h4DBB, 16'h009B, 16'h025F, 16'h0001, 16'h26DE};

    cordic_gain_comp dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .data_in_vec(data_in_vec),
        .rootxy     (rootxy),
        .atanba     (atanba),
        .mag_out    (mag_out),
        .ang_out    (ang_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe for one cycle; returns #1 after the sampling edge (E0).
    task automatic pulse(input logic [15:0] r, input logic [15:0] a);
        @(negedge Clk);
        rootxy      = r;
        atanba      = a;
        data_in_vec = 1'b1;
        @(posedge Clk);
        #1;
        data_in_vec = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            @(posedge Clk);
            #1;
            cyc++;
        end
    endtask

    // Check the head, then pop it with a one-cycle out_ready.
    task automatic pop_one(input string tag, input logic [15:0] m, input logic [15:0] a);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_mag"}, 32'(mag_out), 32'(m));
        check({tag, "_ang"}, 32'(ang_out), 32'(a));
        @(negedge Clk);
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Single transaction with out_ready held high.
    task automatic run_one(input string tag, input logic [15:0] r, input logic [15:0] a,
                           input logic [15:0] m);
        int cyc;
        out_ready = 1'b1;
        pulse(r, a);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_valid(cyc);
        check({tag, "_latency"}, 32'(cyc), 32'd17);
        check({tag, "_mag"}, 32'(mag_out), 32'(m));
        check({tag, "_ang"}, 32'(ang_out), 32'(a));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(posedge Clk);
        #1;
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset       = 1'b0;
        data_in_vec = 1'b0;
        rootxy      = '0;
        atanba      = '0;
        out_ready   = 1'b0;
        #1;
        check("rst_mag", 32'(mag_out), 32'd0);
        check("rst_ang", 32'(ang_out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (100) @(posedge Clk);
        #1;
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Single results
        run_one("v4000", 16'h4000, 16'h1234, 16'h26DE);
        run_one("vFFFF", 16'hFFFF, 16'h1234, 16'h9B75);
        run_one("v0000", 16'h0000, 16'h1234, 16'h0000);
        check("no_overrun", 32'(overrun), 32'd0);

        // Strobe while multiplying is dropped
        out_ready = 1'b0;
        pulse(16'h8000, 16'h0042);
        repeat (4) @(posedge Clk);
        pulse(16'h0100, 16'h0043);
        check("overrun_set", 32'(overrun), 32'd1);
        repeat (30) @(posedge Clk);
        #1;
        pop_one("ovr_entry", 16'h4DBB, 16'h0042);
        check("ovr_single", 32'(out_valid), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Queue four, fifth stalls until the first pop
        for (int k = 0; k < 5; k++) begin
            pulse(vr[k], va[k]);
            repeat (19) @(posedge Clk);
        end
        #1;
        check("stall_busy", 32'(busy), 32'd1);
        pop_one("stall_q0", em[0], va[0]);
        check("stall_released", 32'(busy), 32'd0);
        check("stall_count4", 32'(out_valid), 32'd1);
        for (int k = 1; k < 5; k++) pop_one($sformatf("stall_q%0d", k), em[k], va[k]);
        check("stall_empty", 32'(out_valid), 32'd0);
        check("hold_mag", 32'(mag_out), 32'(em[4]));
        check("hold_ang", 32'(ang_out), 32'(va[4]));

        // Full queue: push and pop on the same edge
        for (int k = 0; k < 4; k++) begin
            pulse(vr[k], va[k]);
            repeat (19) @(posedge Clk);
        end
        pulse(vr[4], va[4]);
        repeat (16) @(posedge Clk);
        #1;
        check("same_full_busy", 32'(busy), 32'd1);
        @(negedge Clk);
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        check("same_push_taken", 32'(busy), 32'd0);
        for (int k = 1; k < 5; k++) pop_one($sformatf("same_q%0d", k), em[k], va[k]);
        check("same_empty", 32'(out_valid), 32'd0);

        // Reset during a multiply with two entries queued
        for (int k = 0; k < 2; k++) begin
            pulse(vr[k], va[k]);
            repeat (19) @(posedge Clk);
        end
        pulse(vr[2], va[2]);
        repeat (8) @(posedge Clk);
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        Reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_mag", 32'(mag_out), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        run_one("post_rst", 16'h8000, 16'h0ABC, 16'h4DBB);
        check("post_rst_overrun", 32'(overrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_gain_comp.md
# cordic_gain_comp

Downstream stage of the vector-mode CORDIC. Captures each completed result (unscaled magnitude `rootxy`, angle `atanba`) on the CORDIC's one-cycle done strobe. Removes the CORDIC gain from the magnitude using a sequential shift-add multiply by K ≈ 0.60725. Queues the corrected (magnitude, angle) pairs in a 4-entry FIFO with a valid/ready output handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, 4, result queue depth (power of two, ≥2)
- `K_COEF`, 16'h4DBB, gain-correction constant in Q1.15 (19899 ≈ 0.60725·2^15)

Ports:
- `Clk`  in  1  single clock, rising-edge
- `Reset`  in  1  asynchronous, active-low reset
- `data_in_vec`  in  1  one-cycle strobe from the CORDIC: `rootxy`/`atanba` valid this cycle
- `rootxy`  in  16  unsigned raw magnitude (gain ≈1.6468 included)
- `atanba`  in  16  signed angle, passed through unchanged
- `mag_out`  out  16  unsigned gain-corrected magnitude at FIFO head
- `ang_out`  out  16  angle at FIFO head
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts head when high with `out_valid`
- `busy`  out  1  state ≠ IDLE
- `overrun`  out  1  sticky; set when a strobe is dropped

## Operation
- Reset (async, `Reset`=0): state IDLE, FIFO empty. All outputs 0: `mag_out`, `ang_out`, `out_valid`, `busy`, `overrun`.
- **IDLE**: on `data_in_vec`=1, latch `rootxy` into the multiplicand and `atanba` into the angle register. Clear the 32-bit accumulator and the 4-bit iteration counter. Go to MUL.
- **MUL**: one iteration per cycle, LSB-first over `K_COEF` bits 0..15.
  - If bit i=1: acc += rootxy << i.
  - After the 16th iteration (counter=15), go to PUSH.
- **PUSH**: result = (acc + 2^14) >> 15, i.e. round-half-up. Width is 16 bits. No saturation is needed because K < 1.
  - FIFO not full: write {result, angle} and go to IDLE.
  - FIFO full: hold in PUSH (stall) until a pop frees a slot.
- Strobes arriving in MUL or PUSH are dropped and set `overrun`. Only reset clears `overrun`.
- FIFO is show-ahead: `mag_out`/`ang_out` present the head entry combinationally from registered storage. When empty, the outputs hold the last popped value (0 after reset).
- Pop occurs on `out_valid && out_ready`.
- Simultaneous push and pop when full: the pop frees the slot in the same cycle and the push is accepted. Count is unchanged.
- Simultaneous push and pop when empty: no bypass. The push lands and `out_valid` rises next cycle.
- Pointers are log2(`FIFO_DEPTH`) bits and wrap naturally. Count is log2(`FIFO_DEPTH`)+1 bits.
- Reset mid-multiply or mid-stall: the in-flight result is discarded and the FIFO is emptied.

## Timing
- Strobe sampled at edge E0 → MUL during E1..E16 → PUSH writes at E17 → `out_valid`=1 after E17. Latency is 17 cycles with FIFO not full.
- Minimum strobe spacing without drop is 18 cycles. A new strobe is accepted at the first edge after returning to IDLE.
- `busy` is high from after E0 through E17.
- `out_valid` falls the cycle after the last entry is popped.
- Stall: each cycle in PUSH with the FIFO full extends latency by one.

## Structure
- Package `cordic_pkg`:
  - `CORDIC_W`=16
  - `K_COEF_DEFAULT`=16'h4DBB
  - `ROUND_BIAS`=32'h4000
  - state enum `gc_state_t` {IDLE, MUL, PUSH}
  - `result_t` struct {mag[15:0], ang[15:0]}
- Sub-module `result_fifo`: parameterised synchronous FIFO of `result_t` with `push`, `pop`, `full`, `empty`. It owns the pointers, count, and same-cycle push/pop rules.
- Top level holds the FSM, the shift-add datapath, and `overrun`.

## Test plan
- Reset then idle: all outputs 0; `out_valid`=0 after 100 cycles with no strobes.
- `rootxy`=16'h4000, `atanba`=16'h1234, strobe; `out_ready`=1 → `out_valid` after 17 edges, `mag_out`=16'h26DE (9950), `ang_out`=16'h1234. Repeat with 16'hFFFF → 16'h9B75; repeat with 0 → 0.
- Strobe at E0 and again at E5 → second dropped, `overrun`=1 and stays 1; exactly one FIFO entry.
- `out_ready`=0, five strobes spaced 20 cycles → 4 entries queued, fifth stalls in PUSH with `busy`=1. Raise `out_ready` → five results popped in order; stalled entry written the cycle the first pop occurs.
- Fill FIFO, pop and push in the same cycle → count stays 4, order preserved. Run 10 pushes/pops to exercise pointer wrap.
- Assert `Reset` at E8 of a multiply with 2 entries queued → `out_valid`, `busy` drop immediately; after release, the next strobe yields the correct single result.
